// File: rtl/fifo_unpacker_pkg.sv
// Shared types and helpers for the fifo_unpacker word-to-chunk serialiser.
package fifo_unpacker_pkg;

  // IDLE: no word held; SHIFT: word held and presented chunk by chunk.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Chunk-index width; kept at least one bit so degenerate ratios still elaborate far enough to report.
  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_unpacker_if.sv
// Bundle of the upstream-fifo and downstream-chunk handshake signals around fifo_unpacker.
interface fifo_unpacker_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 4
);
  logic             fifo_empty;
  logic [IN_W-1:0]  fifo_dout;
  logic             fifo_read;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  // Unpacker side: consumes fifo words, produces chunks.
  modport master (
    input  fifo_empty, fifo_dout, flush, out_ready,
    output fifo_read, out_valid, out_data, out_last
  );

  // Environment side: supplies fifo words, accepts chunks.
  modport slave (
    output fifo_empty, fifo_dout, flush, out_ready,
    input  fifo_read, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sync_fifo.sv
// Team first-word-fall-through fifo: head word is visible on dout_o whenever empty_o is low.
module sync_fifo #(
  parameter int unsigned NUM_ENTRIES = 64,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              full_o,
  input  logic              read_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o
);
  localparam int unsigned AW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned CW = $clog2(NUM_ENTRIES + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(NUM_ENTRIES - 1);

  logic [DATA_W-1:0] r_mem [NUM_ENTRIES];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_wr;
  logic              w_rd;

  assign w_wr    = write_i & ~full_o;
  assign w_rd    = read_i & ~empty_o;
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(NUM_ENTRIES));
  assign dout_o  = r_mem[r_rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= din_i;
  end

  // Pointer and occupancy bookkeeping with wrap at NUM_ENTRIES.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fifo_unpacker.sv
// Pops IN_W-bit words from a FWFT fifo and emits them as RATIO chunks of OUT_W bits, LSB chunk first.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [IN_W-1:0]  fifo_dout_i,
  output logic             fifo_read_o,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_last_o
);
  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned IDX_W = idx_width(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_bad_ratio
    $error("fifo_unpacker: IN_W must be an integer multiple of OUT_W with IN_W/OUT_W >= 2");
  end

  state_t                       r_state;
  logic [IN_W-1:0]              r_word;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_valid;
  logic [OUT_W-1:0]             r_data;
  logic                         r_last;

  logic [RATIO-1:0][OUT_W-1:0]  w_word_chunks;
  logic [IDX_W-1:0]             w_idx_inc;
  logic                         w_handshake;
  logic                         w_at_last;
  logic                         w_pop;

  assign w_word_chunks = r_word;
  assign w_idx_inc     = r_idx + 1'b1;
  assign w_handshake   = r_valid & out_ready_i;
  assign w_at_last     = (r_idx == LAST_IDX);

  // Pop when idle, or when the final chunk leaves and another word is waiting; flush and reset suppress it.
  assign w_pop = ~rst_i & ~fifo_empty_i & ~flush_i &
                 ((r_state == IDLE) | (w_handshake & w_at_last));

  assign fifo_read_o = w_pop;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_last_o  = r_last;

  // Chunk data and last flag are precomputed for the next index so all outputs stay register-driven.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_pop) begin
      r_state <= SHIFT;
      r_word  <= fifo_dout_i;
      r_idx   <= '0;
      r_valid <= 1'b1;
      r_data  <= fifo_dout_i[OUT_W-1:0];
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          if (flush_i || (w_handshake && w_at_last)) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
          end else if (w_handshake) begin
            r_idx  <= w_idx_inc;
            r_data <= w_word_chunks[w_idx_inc];
            r_last <= (w_idx_inc == LAST_IDX);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
